// File: rtl/morph_pkg.sv
// Shared encodings and mode decode for the binary morphology mode controller.
package morph_pkg;

    typedef enum logic [2:0] {
        MODE_BYPASS = 3'd0,
        MODE_ERODE  = 3'd1,
        MODE_DILATE = 3'd2,
        MODE_OPEN   = 3'd3,
        MODE_CLOSE  = 3'd4
    } mode_e;

    localparam logic OP_ERODE  = 1'b0;
    localparam logic OP_DILATE = 1'b1;

    localparam logic [1:0] SEL_RAW     = 2'b00;
    localparam logic [1:0] SEL_STAGE_A = 2'b01;
    localparam logic [1:0] SEL_STAGE_B = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PEND  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    typedef struct packed {
        logic       a_op;
        logic       b_op;
        logic [1:0] sel;
    } stage_cfg_t;

    function automatic logic mode_legal(input logic [2:0] mode);
        return mode <= MODE_CLOSE;
    endfunction

    // Unused stage ops default to erode so the idle stage stays deterministic.
    function automatic stage_cfg_t mode_decode(input logic [2:0] mode);
        stage_cfg_t cfg;
        cfg.a_op = OP_ERODE;
        cfg.b_op = OP_ERODE;
        cfg.sel  = SEL_RAW;
        case (mode)
            MODE_ERODE: begin
                cfg.sel = SEL_STAGE_A;
            end
            MODE_DILATE: begin
                cfg.a_op = OP_DILATE;
                cfg.sel  = SEL_STAGE_A;
            end
            MODE_OPEN: begin
                cfg.b_op = OP_DILATE;
                cfg.sel  = SEL_STAGE_B;
            end
            MODE_CLOSE: begin
                cfg.a_op = OP_DILATE;
                cfg.sel  = SEL_STAGE_B;
            end
            default: ;
        endcase
        return cfg;
    endfunction

endpackage

// File: rtl/morph_line_check.sv
// Counts active pixels per line and flags any line whose length differs from IMG_H.
module morph_line_check #(
    parameter int IMG_H = 83
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic de_in,
    input  logic h_sync_in,
    output logic line_err
);

    localparam int            CW       = $clog2(IMG_H + 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] LINE_LEN = CW'(IMG_H);

    logic [CW-1:0] de_cnt;
    logic          de_d;
    logic          de_fall;

    assign de_fall = de_d && !de_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            de_cnt   <= '0;
            de_d     <= 1'b0;
            line_err <= 1'b0;
        end else begin
            de_d <= de_in;
            if (de_in) begin
                if (de_cnt != CNT_MAX)
                    de_cnt <= de_cnt + CW'(1);
            end else if (de_fall || h_sync_in) begin
                de_cnt <= '0;
            end
            // A mismatch on the same cycle as a clear still wins: never lose an error.
            if (de_fall && de_cnt != LINE_LEN)
                line_err <= 1'b1;
            else if (clr)
                line_err <= 1'b0;
        end
    end

endmodule

// File: rtl/morph_mode_ctrl.sv
// Frame-synchronous mode controller: accepts a mode request, applies it on the next
// v_sync edge, then blanks output for FLUSH_FRAMES frames while line buffers refill.
module morph_mode_ctrl
    import morph_pkg::*;
#(
    parameter int IMG_H        = 83,
    parameter int FLUSH_FRAMES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  mode_req,
    input  logic        mode_req_valid,
    output logic        mode_req_ready,
    input  logic        de_in,
    input  logic        h_sync_in,
    input  logic        v_sync_in,
    output logic        stage_a_op,
    output logic        stage_b_op,
    output logic [1:0]  out_sel,
    output logic        out_blank,
    output logic [2:0]  mode_active,
    output logic        mode_err,
    output logic [15:0] frame_cnt,
    output logic        line_err
);

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_FRAMES);

    state_e     state, state_nxt;
    logic [2:0] pend_mode, pend_nxt;
    logic [3:0] flush_cnt, flush_nxt;
    stage_cfg_t cfg_q, cfg_nxt;
    logic [2:0] mode_nxt;
    logic       blank_nxt;
    logic       err_nxt;
    logic       ready_nxt;
    logic       vs_d;
    logic       vs_edge;
    logic       hs;
    logic       req_ok;

    assign vs_edge = v_sync_in && !vs_d;
    assign hs      = mode_req_valid && mode_req_ready;

    assign stage_a_op = cfg_q.a_op;
    assign stage_b_op = cfg_q.b_op;
    assign out_sel    = cfg_q.sel;

    always_comb begin
        state_nxt = state;
        pend_nxt  = pend_mode;
        flush_nxt = flush_cnt;
        cfg_nxt   = cfg_q;
        mode_nxt  = mode_active;
        blank_nxt = out_blank;
        err_nxt   = 1'b0;
        req_ok    = 1'b0;
        case (state)
            ST_RUN: begin
                if (hs) begin
                    if (mode_legal(mode_req)) begin
                        req_ok    = 1'b1;
                        pend_nxt  = mode_req;
                        state_nxt = ST_PEND;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            // An edge coincident with the handshake was seen while still in RUN,
            // so the apply naturally waits for the following edge.
            ST_PEND: begin
                if (vs_edge) begin
                    cfg_nxt   = mode_decode(pend_mode);
                    mode_nxt  = pend_mode;
                    blank_nxt = 1'b1;
                    flush_nxt = FLUSH_INIT;
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (vs_edge) begin
                    flush_nxt = flush_cnt - 4'd1;
                    if (flush_cnt <= 4'd1) begin
                        flush_nxt = '0;
                        blank_nxt = 1'b0;
                        state_nxt = ST_RUN;
                    end
                end
            end
            default: state_nxt = ST_RUN;
        endcase
        ready_nxt = (state_nxt == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_RUN;
            pend_mode      <= '0;
            flush_cnt      <= '0;
            cfg_q          <= mode_decode(MODE_BYPASS);
            mode_active    <= '0;
            out_blank      <= 1'b0;
            mode_err       <= 1'b0;
            mode_req_ready <= 1'b1;
            vs_d           <= 1'b0;
            frame_cnt      <= '0;
        end else begin
            state          <= state_nxt;
            pend_mode      <= pend_nxt;
            flush_cnt      <= flush_nxt;
            cfg_q          <= cfg_nxt;
            mode_active    <= mode_nxt;
            out_blank      <= blank_nxt;
            mode_err       <= err_nxt;
            mode_req_ready <= ready_nxt;
            vs_d           <= v_sync_in;
            if (vs_edge)
                frame_cnt <= frame_cnt + 16'd1;
        end
    end

    morph_line_check #(.IMG_H(IMG_H)) u_line_check (
        .clk       (clk),
        .rst       (rst),
        .clr       (req_ok),
        .de_in     (de_in),
        .h_sync_in (h_sync_in),
        .line_err  (line_err)
    );

endmodule

// File: tb/tb_morph_mode_ctrl.sv
// Directed bench for morph_mode_ctrl: one instance with 1 flush frame, one with 3.
module tb_morph_mode_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  mode_req;
    logic        mode_req_valid;
    logic        de_in, h_sync_in, v_sync_in;

    logic        rdy1, a1, b1, blank1, err1, lerr1;
    logic [1:0]  sel1;
    logic [2:0]  mode1;
    logic [15:0] fcnt1;
    logic        rdy3, a3, b3, blank3, err3, lerr3;
    logic [1:0]  sel3;
    logic [2:0]  mode3;
    logic [15:0] fcnt3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    morph_mode_ctrl #(.IMG_H(83), .FLUSH_FRAMES(1)) dut1 (
        .clk(clk), .rst(rst), .mode_req(mode_req), .mode_req_valid(mode_req_valid),
        .mode_req_ready(rdy1), .de_in(de_in), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
        .stage_a_op(a1), .stage_b_op(b1), .out_sel(sel1), .out_blank(blank1),
        .mode_active(mode1), .mode_err(err1), .frame_cnt(fcnt1), .line_err(lerr1)
    );

    morph_mode_ctrl #(.IMG_H(83), .FLUSH_FRAMES(3)) dut3 (
        .clk(clk), .rst(rst), .mode_req(mode_req), .mode_req_valid(mode_req_valid),
        .mode_req_ready(rdy3), .de_in(de_in), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
        .stage_a_op(a3), .stage_b_op(b3), .out_sel(sel3), .out_blank(blank3),
        .mode_active(mode3), .mode_err(err3), .frame_cnt(fcnt3), .line_err(lerr3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic vs_hi();
        v_sync_in = 1'b1;
        step();
    endtask

    task automatic vs_lo();
        v_sync_in = 1'b0;
        step();
    endtask

    task automatic line(input int n);
        de_in = 1'b1;
        step(n);
        de_in = 1'b0;
        step();
    endtask

    task automatic hsync();
        h_sync_in = 1'b1;
        step();
        h_sync_in = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; mode_req = '0; mode_req_valid = 1'b0;
        de_in = 1'b0; h_sync_in = 1'b0; v_sync_in = 1'b0;
        step(2);
        rst = 1'b0;
        chk("rst_ready", rdy1, 1);
        chk("rst_mode", mode1, 0);
        chk("rst_cfg", {a1, b1, sel1}, 4'b0000);
        chk("rst_blank", blank1, 0);
        chk("rst_err", err1, 0);
        chk("rst_fcnt", fcnt1, 0);
        chk("rst_lerr", lerr1, 0);

        // OPEN request; apply on next edge; 1 flush frame on dut1, 3 on dut3
        mode_req = 3'd3; mode_req_valid = 1'b1;
        step();
        mode_req_valid = 1'b0;
        chk("open_ready_drop", rdy1, 0);
        step(2);
        chk("open_not_yet", mode1, 0);
        vs_hi();
        chk("open_cfg", {a1, b1, sel1}, 4'b0110);
        chk("open_mode", mode1, 3);
        chk("open_blank", blank1, 1);
        chk("open_fcnt", fcnt1, 1);
        vs_lo();
        vs_hi();
        chk("ff1_blank_clr", blank1, 0);
        chk("ff1_ready", rdy1, 1);
        chk("ff3_blank_e1", blank3, 1);
        vs_lo();
        vs_hi();
        chk("ff3_blank_e2", blank3, 1);
        chk("ff3_ready_e2", rdy3, 0);
        vs_lo();
        vs_hi();
        chk("ff3_blank_e3", blank3, 0);
        chk("ff3_ready_e3", rdy3, 1);
        chk("ff3_fcnt", fcnt3, 4);
        vs_lo();

        // illegal request
        mode_req = 3'd6; mode_req_valid = 1'b1;
        step();
        mode_req_valid = 1'b0;
        chk("ill_err", err1, 1);
        chk("ill_ready", rdy1, 1);
        step();
        chk("ill_err_pulse", err1, 0);
        chk("ill_mode", mode1, 3);

        // request coincident with an edge waits for the next edge
        mode_req = 3'd2; mode_req_valid = 1'b1; v_sync_in = 1'b1;
        step();
        mode_req_valid = 1'b0;
        chk("coin_mode_hold", mode1, 3);
        chk("coin_ready", rdy1, 0);
        chk("coin_fcnt", fcnt1, 5);
        vs_lo();
        vs_hi();
        chk("coin_cfg", {a1, b1, sel1}, 4'b1001);
        chk("coin_mode", mode1, 2);
        chk("coin_blank", blank1, 1);
        vs_lo();
        vs_hi();
        chk("coin_blank_clr", blank1, 0);
        vs_lo();

        // line length checks
        line(83);
        hsync();
        chk("line83", lerr1, 0);
        line(82);
        chk("line82", lerr1, 1);
        hsync();
        line(83);
        chk("line_sticky", lerr1, 1);
        mode_req = 3'd4; mode_req_valid = 1'b1;
        step();
        mode_req_valid = 1'b0;
        chk("lerr_clear", lerr1, 0);

        // apply CLOSE, then reset mid-flush
        vs_hi();
        chk("close_cfg", {a1, b1, sel1}, 4'b1010);
        chk("close_blank", blank1, 1);
        vs_lo();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_flush_mode", mode1, 0);
        chk("rst_flush_cfg", {a1, b1, sel1}, 4'b0000);
        chk("rst_flush_blank", blank1, 0);
        chk("rst_flush_ready", rdy1, 1);
        chk("rst_flush_fcnt", fcnt1, 0);

        // reset discards a pending request
        mode_req = 3'd1; mode_req_valid = 1'b1;
        step();
        mode_req_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        vs_hi();
        chk("pend_drop_mode", mode1, 0);
        chk("pend_drop_blank", blank1, 0);
        chk("pend_drop_ready", rdy1, 1);
        vs_lo();

        // frame counter wrap
        force dut1.frame_cnt = 16'hFFFF;
        step();
        release dut1.frame_cnt;
        step();
        chk("fcnt_preset", fcnt1, 32'h0000FFFF);
        vs_hi();
        chk("fcnt_wrap", fcnt1, 0);
        vs_lo();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/morph_mode_ctrl.md
# morph_mode_ctrl

Frame-synchronous mode controller for the binary morphology pipeline (erosion and dilatation stages with sync pass-through). It accepts a requested operation (bypass, erode, dilate, open, close) over a valid/ready handshake and applies it only at a vertical-sync boundary. It then blanks the output for a configurable number of flush frames while the stage line buffers refill. It also counts frames and checks every active line against the configured line length.

## Interface
- IMG_H, 83, active pixels per line; must match the stage line-buffer length
- FLUSH_FRAMES, 1, frames of forced blanking after a mode switch (1..15)
- clk  in  1  pixel clock, all logic rising-edge
- rst  in  1  synchronous reset, active-high
- mode_req  in  3  requested mode (0 BYPASS, 1 ERODE, 2 DILATE, 3 OPEN, 4 CLOSE; 5-7 illegal)
- mode_req_valid  in  1  request strobe; hold with mode_req stable until ready
- mode_req_ready  out  1  request accepted on valid&&ready
- de_in, h_sync_in, v_sync_in  in  1 each  video timing at pipeline input
- stage_a_op  out  1  first stage: 0 erode, 1 dilate
- stage_b_op  out  1  second stage: 0 erode, 1 dilate
- out_sel  out  2  output mux: 00 raw mask, 01 stage A, 10 stage B
- out_blank  out  1  force pipeline output to 0
- mode_active  out  3  mode currently applied
- mode_err  out  1  one-cycle pulse on illegal request
- frame_cnt  out  16  v_sync rising-edge count, wraps
- line_err  out  1  sticky: a line had de_in count != IMG_H

## Operation
- Mode map: BYPASS a=0,b=0,sel=00; ERODE a=0,sel=01; DILATE a=1,sel=01; OPEN a=0,b=1,sel=10; CLOSE a=1,b=0,sel=10.
- FSM states RUN, PEND, FLUSH.
  - RUN: ready=1. Legal handshake: latch mode into pending register, go to PEND. Illegal handshake: mode_err pulse, stay in RUN, config unchanged.
  - PEND: ready=0. On the next v_sync rising edge, load config from the pending register, set out_blank=1, load flush counter with FLUSH_FRAMES, go to FLUSH.
  - FLUSH: ready=0. Each v_sync rising edge decrements the counter. On reaching 0, clear out_blank and go to RUN.
- v_sync edge: registered v_sync_d. An edge is v_sync_in && !v_sync_d.
- A handshake in RUN on the same cycle as an edge goes to PEND and waits for the following edge, not the current one.
- Re-requesting the active mode still performs a full PEND/FLUSH cycle.
- frame_cnt increments on every edge in every state and wraps from 0xFFFF to 0.
- Line check: count de_in high cycles. On the de_in falling edge, compare the count with IMG_H and set line_err on mismatch, then clear the count.
  - The counter saturates at 2^clog2(IMG_H+1)-1.
  - line_err clears only on rst or on an accepted legal request.
- h_sync_in is used only to clear a partial pixel count when de_in is low.

## Timing
- Reset values:
  - state RUN, ready=1
  - mode_active=0, stage_a_op=0, stage_b_op=0, out_sel=00
  - out_blank=0, mode_err=0, frame_cnt=0, line_err=0
  - flush counter 0, pending register 0
- All outputs are registered.
- Handshake at cycle N: ready=0 at N+1. mode_err, if raised, is high at N+1 only.
- Edge at cycle E in PEND: new config and out_blank=1 visible at E+1. Edge in FLUSH that reaches 0: out_blank=0 and ready=1 at E+1.
- frame_cnt updates at E+1.
- line_err is set 1 cycle after the de_in falling edge is sampled.
- rst in any state (including mid-FLUSH):
  - all outputs return to reset values next cycle
  - any pending request is discarded

## Structure
- Package morph_pkg holds:
  - mode encodings
  - op encodings (OP_ERODE=0, OP_DILATE=1)
  - out_sel encodings
  - FSM state enum
  - mode→config decode function
- Sub-module morph_line_check holds the de counter, mismatch compare and sticky flag, parameterised by IMG_H.
- The top level holds the edge detect, FSM, flush counter and frame counter.

## Test plan
- Reset, then mode_req=3 valid in RUN → ready drops the next cycle. At the next v_sync edge: a=0, b=1, sel=10, mode_active=3, out_blank=1. Blank clears one frame later (FLUSH_FRAMES=1).
- mode_req=6 valid → mode_err pulses for 1 cycle, ready stays 1, mode_active unchanged.
- Request coincident with a v_sync edge → config changes only at the second edge.
- FLUSH_FRAMES=3: out_blank is high across exactly 3 edges after the apply edge, and frame_cnt advances by 4 overall.
- Lines of 83, 82 and 83 pixels → line_err set after the second line and still set after the third. A legal request clears it.
- rst asserted mid-FLUSH → next cycle BYPASS, out_blank=0, ready=1. frame_cnt preset to 0xFFFF wraps to 0 on the next edge.
